// File: rtl/of_unit.sv
// Operand-fetch stage: owns the 16x32 register file, decodes the fetched
// instruction, builds immediate and branch target, and registers the
// resulting operand bundle for execute.
module of_unit #(
  parameter int NUM_REGS = 16,
  parameter int RA_IDX   = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] pc_in,
  input  logic [31:0] inst_in,
  input  logic        stall,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [3:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic        of_valid,
  output logic [31:0] of_pc,
  output logic [31:0] of_inst,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic [31:0] store_data,
  output logic [31:0] imm_ext,
  output logic [31:0] branch_target
);

  localparam logic [4:0] OP_ST  = 5'd15;
  localparam logic [4:0] OP_RET = 5'd20;
  localparam logic [3:0] RA     = 4'(RA_IDX);

  logic [31:0] regs [NUM_REGS];

  logic [4:0]  opcode;
  logic        i_bit;
  logic [3:0]  rd;
  logic [3:0]  rs1;
  logic [3:0]  rs2;
  logic [1:0]  modifier;
  logic [15:0] imm16;

  logic [3:0]  rs1_sel;
  logic [3:0]  rs2_sel;
  logic [31:0] read_a;
  logic [31:0] read_b;
  logic [31:0] read_d;
  logic [31:0] imm_next;
  logic [31:0] op_b_next;
  logic [31:0] target_next;

  assign opcode   = inst_in[31:27];
  assign i_bit    = inst_in[26];
  assign rd       = inst_in[25:22];
  assign rs1      = inst_in[21:18];
  assign rs2      = inst_in[17:14];
  assign modifier = inst_in[17:16];
  assign imm16    = inst_in[15:0];

  // ret reads the return-address register; st reads its data register as rs2
  assign rs1_sel = (opcode == OP_RET) ? RA : rs1;
  assign rs2_sel = (opcode == OP_ST)  ? rd : rs2;

  // Write-first bypass so an instruction sees a same-cycle writeback
  assign read_a = (wb_en && wb_rd == rs1_sel) ? wb_data : regs[rs1_sel];
  assign read_b = (wb_en && wb_rd == rs2_sel) ? wb_data : regs[rs2_sel];
  assign read_d = (wb_en && wb_rd == rd)      ? wb_data : regs[rd];

  // Immediate extension selected by the modifier bits; 11 behaves as 00
  always_comb begin
    imm_next = {{16{imm16[15]}}, imm16};
    case (modifier)
      2'b01:   imm_next = {16'h0000, imm16};
      2'b10:   imm_next = {imm16, 16'h0000};
      default: imm_next = {{16{imm16[15]}}, imm16};
    endcase
  end

  assign op_b_next   = i_bit ? imm_next : read_b;
  assign target_next = pc_in + {{3{inst_in[26]}}, inst_in[26:0], 2'b00};

  // Register file: synchronous write, every index including r0 writable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en) begin
      regs[wb_rd] <= wb_data;
    end
  end

  // IF/OF pipeline register: flush clears valid, stall freezes everything
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      of_valid      <= 1'b0;
      of_pc         <= '0;
      of_inst       <= '0;
      op_a          <= '0;
      op_b          <= '0;
      store_data    <= '0;
      imm_ext       <= '0;
      branch_target <= '0;
    end else if (flush) begin
      of_valid <= 1'b0;
    end else if (!stall) begin
      of_valid      <= if_valid;
      of_pc         <= pc_in;
      of_inst       <= inst_in;
      op_a          <= read_a;
      op_b          <= op_b_next;
      store_data    <= read_d;
      imm_ext       <= imm_next;
      branch_target <= target_next;
    end
  end

endmodule

// File: tb/tb_of_unit.sv
// Self-checking bench for of_unit: directed vector table, hand-written
// stall/flush/reset sequences, and randomized traffic against a
// behavioural model of the stage.
module tb_of_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_valid = 1'b0;
  logic [31:0] pc_in = '0;
  logic [31:0] inst_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        wb_en = 1'b0;
  logic [3:0]  wb_rd = '0;
  logic [31:0] wb_data = '0;
  logic        of_valid;
  logic [31:0] of_pc, of_inst, op_a, op_b, store_data, imm_ext, branch_target;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] ref_regs [16];
  logic        m_valid;
  logic [31:0] m_pc, m_inst, m_op_a, m_op_b, m_store, m_imm, m_bt;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        wb_en;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic [4:0]  mask;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] store;
    logic [31:0] imm;
    logic [31:0] bt;
  } vec_t;

  vec_t vecs [12];

  of_unit dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .pc_in(pc_in), .inst_in(inst_in),
    .stall(stall), .flush(flush), .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .of_valid(of_valid), .of_pc(of_pc), .of_inst(of_inst), .op_a(op_a), .op_b(op_b),
    .store_data(store_data), .imm_ext(imm_ext), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] enc(input logic [4:0] op, input logic i, input logic [3:0] rd,
                                      input logic [3:0] rs1, input logic [17:0] imm);
    return {op, i, rd, rs1, imm};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) ref_regs[i] = '0;
    m_valid = 1'b0;
    m_pc = '0; m_inst = '0; m_op_a = '0; m_op_b = '0;
    m_store = '0; m_imm = '0; m_bt = '0;
  endtask

  // Architectural register read as seen during the current cycle
  function automatic logic [31:0] readReg(input int idx);
    if (wb_en && int'(wb_rd) == idx) return wb_data;
    return ref_regs[idx];
  endfunction

  // Behavioural effect of one rising edge with the currently driven inputs
  task automatic modelEdge();
    int op, rd_i, rs1_i, rs2_i;
    logic signed [31:0] simm;
    logic signed [31:0] off;
    logic [31:0] imm_v;
    if (flush) begin
      m_valid = 1'b0;
    end else if (!stall) begin
      op    = int'(inst_in[31:27]);
      rd_i  = int'(inst_in[25:22]);
      rs1_i = int'(inst_in[21:18]);
      rs2_i = int'(inst_in[17:14]);
      simm  = $signed(inst_in[15:0]);
      if (inst_in[17:16] == 2'd1)      imm_v = 32'(inst_in[15:0]);
      else if (inst_in[17:16] == 2'd2) imm_v = 32'(inst_in[15:0]) * 32'd65536;
      else                             imm_v = simm;
      off     = $signed(inst_in[26:0]);
      m_valid = if_valid;
      m_pc    = pc_in;
      m_inst  = inst_in;
      m_op_a  = readReg(op == 20 ? 15 : rs1_i);
      m_op_b  = inst_in[26] ? imm_v : readReg(op == 15 ? rd_i : rs2_i);
      m_store = readReg(rd_i);
      m_imm   = imm_v;
      m_bt    = pc_in + off * 4;
    end
    if (wb_en) ref_regs[wb_rd] = wb_data;
  endtask

  task automatic checkOutput();
    check("of_valid", {31'b0, of_valid}, {31'b0, m_valid});
    check("of_pc", of_pc, m_pc);
    check("of_inst", of_inst, m_inst);
    check("op_a", op_a, m_op_a);
    check("op_b", op_b, m_op_b);
    check("store_data", store_data, m_store);
    check("imm_ext", imm_ext, m_imm);
    check("branch_target", branch_target, m_bt);
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                               input logic st, input logic fl, input logic we,
                               input logic [3:0] wr, input logic [31:0] wd);
    if_valid = v; pc_in = pc; inst_in = inst; stall = st; flush = fl;
    wb_en = we; wb_rd = wr; wb_data = wd;
    modelEdge();
    @(posedge clk);
    #1;
    checkOutput();
  endtask

  initial begin
    modelReset();
    vecs[0]  = '{32'h0, enc(5'd0, 1'b0, 4'd1, 4'd3, {4'd3, 14'd0}), 1'b0, 4'd0, 32'h0,
                 5'b00011, 32'hAA, 32'hAA, 32'h0, 32'h0, 32'h0};
    vecs[1]  = '{32'h4, enc(5'd0, 1'b1, 4'd1, 4'd0, {2'b00, 16'h8001}), 1'b0, 4'd0, 32'h0,
                 5'b01010, 32'h0, 32'hFFFF8001, 32'h0, 32'hFFFF8001, 32'h0};
    vecs[2]  = '{32'h8, enc(5'd0, 1'b1, 4'd1, 4'd0, {2'b01, 16'h8001}), 1'b0, 4'd0, 32'h0,
                 5'b01010, 32'h0, 32'h00008001, 32'h0, 32'h00008001, 32'h0};
    vecs[3]  = '{32'hC, enc(5'd0, 1'b1, 4'd1, 4'd0, {2'b10, 16'h8001}), 1'b0, 4'd0, 32'h0,
                 5'b01010, 32'h0, 32'h80010000, 32'h0, 32'h80010000, 32'h0};
    vecs[4]  = '{32'h10, enc(5'd0, 1'b1, 4'd1, 4'd0, {2'b11, 16'h8001}), 1'b0, 4'd0, 32'h0,
                 5'b01010, 32'h0, 32'hFFFF8001, 32'h0, 32'hFFFF8001, 32'h0};
    vecs[5]  = '{32'h14, enc(5'd1, 1'b0, 4'd2, 4'd5, {4'd0, 14'd0}), 1'b1, 4'd5, 32'h1234,
                 5'b00011, 32'h1234, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[6]  = '{32'h100, {5'd16, 27'h7FFFFFF}, 1'b0, 4'd0, 32'h0,
                 5'b10000, 32'h0, 32'h0, 32'h0, 32'h0, 32'hFC};
    vecs[7]  = '{32'h100, {5'd16, 27'd4}, 1'b0, 4'd0, 32'h0,
                 5'b10000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h110};
    vecs[8]  = '{32'h18, enc(5'd20, 1'b0, 4'd0, 4'd0, 18'd0), 1'b0, 4'd0, 32'h0,
                 5'b00001, 32'h40, 32'h0, 32'h0, 32'h0, 32'h0};
    vecs[9]  = '{32'h1C, enc(5'd15, 1'b1, 4'd7, 4'd2, {2'b00, 16'd4}), 1'b0, 4'd0, 32'h0,
                 5'b01111, 32'h22, 32'h4, 32'h55, 32'h4, 32'h0};
    vecs[10] = '{32'hFFFFFFFC, {5'd16, 27'd4}, 1'b0, 4'd0, 32'h0,
                 5'b10000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0000000C};
    vecs[11] = '{32'h100, {5'd16, 27'h4000000}, 1'b0, 4'd0, 32'h0,
                 5'b10000, 32'h0, 32'h0, 32'h0, 32'h0, 32'hF0000100};

    // Reset state
    #12;
    check("reset_of_valid", {31'b0, of_valid}, 32'h0);
    check("reset_op_a", op_a, 32'h0);
    check("reset_branch_target", branch_target, 32'h0);
    rst = 1'b0;

    // Preload registers through the writeback port with bubbles in flight
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd3,  32'hAA);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd15, 32'h40);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd7,  32'h55);
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1, 4'd2,  32'h22);

    // Directed vector table
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1'b1, vecs[k].pc, vecs[k].inst, 1'b0, 1'b0,
                    vecs[k].wb_en, vecs[k].wb_rd, vecs[k].wb_data);
      check($sformatf("vec%0d_valid", k), {31'b0, of_valid}, 32'h1);
      if (vecs[k].mask[0]) check($sformatf("vec%0d_op_a", k), op_a, vecs[k].op_a);
      if (vecs[k].mask[1]) check($sformatf("vec%0d_op_b", k), op_b, vecs[k].op_b);
      if (vecs[k].mask[2]) check($sformatf("vec%0d_store", k), store_data, vecs[k].store);
      if (vecs[k].mask[3]) check($sformatf("vec%0d_imm", k), imm_ext, vecs[k].imm);
      if (vecs[k].mask[4]) check($sformatf("vec%0d_bt", k), branch_target, vecs[k].bt);
    end

    // Stall three cycles with changing fetch and a writeback to a held source
    applyStimulus(1'b1, 32'h200, enc(5'd0, 1'b0, 4'd1, 4'd3, {4'd3, 14'd0}), 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    check("pre_stall_op_a", op_a, 32'hAA);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h300 + 32'(k), $urandom, 1'b1, 1'b0, 1'b1, 4'd3, 32'hBEEF0000 + 32'(k));
      check("stall_valid", {31'b0, of_valid}, 32'h1);
      check("stall_pc", of_pc, 32'h200);
      check("stall_op_a", op_a, 32'hAA);
    end
    // Flush beats stall
    applyStimulus(1'b1, 32'h400, $urandom, 1'b1, 1'b1, 1'b0, 4'd0, 32'h0);
    check("flush_stall_valid", {31'b0, of_valid}, 32'h0);
    check("flush_stall_pc", of_pc, 32'h200);
    // Written-during-stall value is visible to the next fetch
    applyStimulus(1'b1, 32'h500, enc(5'd0, 1'b0, 4'd1, 4'd3, {4'd3, 14'd0}), 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    check("post_stall_op_a", op_a, 32'hBEEF0002);

    // Asynchronous reset between edges while valid
    #2;
    rst = 1'b1;
    #1;
    modelReset();
    check("async_rst_valid", {31'b0, of_valid}, 32'h0);
    check("async_rst_pc", of_pc, 32'h0);
    check("async_rst_op_a", op_a, 32'h0);
    check("async_rst_store", store_data, 32'h0);
    #1;
    rst = 1'b0;
    applyStimulus(1'b1, 32'h600, enc(5'd0, 1'b0, 4'd1, 4'd3, {4'd3, 14'd0}), 1'b0, 1'b0, 1'b0, 4'd0, 32'h0);
    check("r3_after_reset", op_a, 32'h0);

    // Randomized traffic against the reference model
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, $urandom,
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
